// File: rtl/mem_ctrl.sv
// Unified fetch/load/store bus port: one outstanding transaction, byte-lane steering,
// load extension and a wait-state timeout. Optional misaligned-access trap: MISALIGN_TRAP_EN.
module mem_ctrl #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = 32'h00000013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] result,
  input  logic        adr_src,
  input  logic        ir_write,
  input  logic        mem_write,
  input  logic        load_req,
  input  logic [2:0]  funct3,
  input  logic [31:0] write_data,
  output logic        busy,
  output logic [31:0] instr,
  output logic [31:0] old_pc,
  output logic [31:0] read_data,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
`ifdef MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_t;

  state_t        state, state_nx;
  kind_t         kind_q, req_kind;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [31:0]   pc_q;
  logic [CW-1:0] cnt;

  logic        any_req, mis, tmo;
  logic [31:0] addr;
  logic [1:0]  off, size;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign any_req = ir_write | mem_write | load_req;
  assign addr    = adr_src ? result : pc;
  assign off     = addr[1:0];
  // funct3[1:0]: 00 byte, 01 half, anything else (incl. undefined codes) is word
  assign size    = funct3[1:0];

  always_comb begin
    req_kind = K_LOAD;
    if (ir_write)       req_kind = K_FETCH;
    else if (mem_write) req_kind = K_STORE;
  end

  always_comb begin
    st_wdata = write_data;
    st_wstrb = 4'b1111;
    case (size)
      2'b00: begin
        st_wdata = {4{write_data[7:0]}};
        st_wstrb = 4'b0001 << off;
      end
      2'b01: begin
        st_wdata = {2{write_data[15:0]}};
        st_wstrb = off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    mis = 1'b0;
    if (req_kind == K_FETCH) mis = (off != 2'b00);
    else if (size == 2'b01)  mis = off[0];
    else if (size != 2'b00)  mis = (off != 2'b00);
  end
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    ld_byte = bus_rdata[7:0];
    case (off_q)
      2'b01:   ld_byte = bus_rdata[15:8];
      2'b10:   ld_byte = bus_rdata[23:16];
      2'b11:   ld_byte = bus_rdata[31:24];
      default: ;
    endcase
    ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = bus_rdata;
    endcase
  end

  // Ack in the final allowed cycle still completes normally
  assign tmo = (state == WAIT) && !bus_ack && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      IDLE: if (any_req) begin
        busy     = 1'b1;
        state_nx = mis ? DONE : WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (bus_ack || tmo) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kind_q    <= K_FETCH;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      pc_q      <= 32'h0;
      cnt       <= '0;
      instr     <= 32'h0;
      old_pc    <= 32'h0;
      read_data <= 32'h0;
      bus_err   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      bus_wstrb <= 4'h0;
`ifdef MISALIGN_TRAP_EN
      misalign  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (any_req) begin
          kind_q   <= req_kind;
          f3_q     <= funct3;
          off_q    <= off;
          pc_q     <= pc;
          cnt      <= '0;
          bus_addr <= {addr[31:2], 2'b00};
          if (mis) begin
            read_data <= 32'h0;
`ifdef MISALIGN_TRAP_EN
            misalign  <= 1'b1;
`endif
          end else begin
            bus_req   <= 1'b1;
            bus_we    <= (req_kind == K_STORE);
            bus_wdata <= (req_kind == K_STORE) ? st_wdata : 32'h0;
            bus_wstrb <= (req_kind == K_STORE) ? st_wstrb : 4'h0;
          end
        end
        WAIT: begin
          cnt <= cnt + CW'(1);
          if (bus_ack || tmo) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_wstrb <= 4'h0;
          end
          if (bus_ack) begin
            if (kind_q == K_FETCH) begin
              instr  <= bus_rdata;
              old_pc <= pc_q;
            end else if (kind_q == K_LOAD) begin
              read_data <= ld_data;
            end
          end else if (tmo) begin
            bus_err <= 1'b1;
            if (kind_q == K_FETCH)     instr     <= NOP_INSTR;
            else if (kind_q == K_LOAD) read_data <= 32'h0;
          end
        end
        DONE: begin
`ifdef MISALIGN_TRAP_EN
          misalign <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl (default build, TIMEOUT_CYCLES = 4).
module tb_mem_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc, result, write_data, bus_rdata;
  logic        adr_src, ir_write, mem_write, load_req, bus_ack;
  logic [2:0]  funct3;
  logic        busy, bus_err, bus_req, bus_we;
  logic [31:0] instr, old_pc, read_data, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Bus values captured in the first WAIT cycle of a transaction
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_wstrb;
  logic        c_we, c_req;
  int          busy_cyc;

  mem_ctrl #(.TIMEOUT_CYCLES(4), .NOP_INSTR(32'h00000013)) dut (
    .clock(clock), .reset(reset), .pc(pc), .result(result), .adr_src(adr_src),
    .ir_write(ir_write), .mem_write(mem_write), .load_req(load_req), .funct3(funct3),
    .write_data(write_data), .busy(busy), .instr(instr), .old_pc(old_pc),
    .read_data(read_data), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
`ifdef MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered mid-cycle in IDLE; returns mid-cycle in DONE. Ack arrives after `waits` WAIT cycles.
  task automatic txn(input logic iw, input logic mw, input logic ld, input logic as,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input int waits);
    busy_cyc = 0;
    ir_write = iw; mem_write = mw; load_req = ld; adr_src = as; funct3 = f3;
    if (as) result = a; else pc = a;
    write_data = wd; bus_rdata = rd;
    #1 if (busy) busy_cyc++;
    tick();
    ir_write = 1'b0; mem_write = 1'b0; load_req = 1'b0;
    c_addr = bus_addr; c_wdata = bus_wdata; c_wstrb = bus_wstrb; c_we = bus_we; c_req = bus_req;
    if (busy) busy_cyc++;
    for (int i = 0; i < waits; i++) begin
      tick();
      if (busy) busy_cyc++;
    end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    #1 if (busy) busy_cyc++;
  endtask

  initial begin
    reset = 1'b1; pc = 32'h0; result = 32'h0; write_data = 32'h0; bus_rdata = 32'h0;
    adr_src = 1'b0; ir_write = 1'b0; mem_write = 1'b0; load_req = 1'b0; bus_ack = 1'b0;
    funct3 = 3'b010;
    repeat (2) tick();
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_req", {31'h0, bus_req}, 32'h0);
    chk("rst_we", {31'h0, bus_we}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_old_pc", old_pc, 32'h0);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_err", {31'h0, bus_err}, 32'h0);
    reset = 1'b0;
    tick();

    // Reset during WAIT: bus_req drops at once, no register update
    pc = 32'h40; ir_write = 1'b1; bus_rdata = 32'hCAFEF00D;
    tick();
    ir_write = 1'b0;
    chk("midrst_req_before", {31'h0, bus_req}, 32'h1);
    reset = 1'b1;
    #1;
    chk("midrst_req", {31'h0, bus_req}, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_instr", instr, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Fetch with two wait cycles
    txn(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h00A00093, 2);
    chk("f_addr", c_addr, 32'h100);
    chk("f_we", {31'h0, c_we}, 32'h0);
    chk("f_wstrb", {28'h0, c_wstrb}, 32'h0);
    chk("f_busy_cyc", busy_cyc, 32'd4);
    chk("f_req_done", {31'h0, bus_req}, 32'h0);
    chk("f_instr", instr, 32'h00A00093);
    chk("f_old_pc", old_pc, 32'h100);
    tick();

    // Loads, zero-wait
    txn(1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 32'h203, 32'h0, 32'h80FF0000, 0);
    chk("lb_addr", c_addr, 32'h200);
    chk("lb_busy_cyc", busy_cyc, 32'd2);
    chk("lb_data", read_data, 32'hFFFFFF80);
    tick();
    txn(1'b0, 1'b0, 1'b1, 1'b1, 3'b100, 32'h203, 32'h0, 32'h80FF0000, 0);
    chk("lbu_data", read_data, 32'h00000080);
    tick();
    txn(1'b0, 1'b0, 1'b1, 1'b1, 3'b001, 32'h202, 32'h0, 32'h80FF0000, 1);
    chk("lh_data", read_data, 32'hFFFF80FF);
    tick();
    txn(1'b0, 1'b0, 1'b1, 1'b1, 3'b101, 32'h202, 32'h0, 32'h80FF0000, 0);
    chk("lhu_data", read_data, 32'h000080FF);
    tick();
    txn(1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 32'h200, 32'h0, 32'h12345678, 0);
    chk("lw_data", read_data, 32'h12345678);
    chk("lw_wstrb", {28'h0, c_wstrb}, 32'h0);
    tick();
    txn(1'b0, 1'b0, 1'b1, 1'b1, 3'b011, 32'h201, 32'h0, 32'h8765ABCD, 0);
    chk("l011_data", read_data, 32'h8765ABCD);
    tick();

    // Stores
    txn(1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 32'h301, 32'h000000AB, 32'h0, 0);
    chk("sb_we", {31'h0, c_we}, 32'h1);
    chk("sb_wstrb", {28'h0, c_wstrb}, 32'h2);
    chk("sb_wdata", c_wdata, 32'hABABABAB);
    chk("sb_addr", c_addr, 32'h300);
    chk("sb_rd_kept", read_data, 32'h8765ABCD);
    tick();
    txn(1'b0, 1'b1, 1'b0, 1'b1, 3'b001, 32'h302, 32'h00001234, 32'h0, 0);
    chk("sh_wstrb", {28'h0, c_wstrb}, 32'hC);
    chk("sh_wdata", c_wdata, 32'h12341234);
    tick();
    txn(1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 32'h304, 32'hDEADBEEF, 32'h0, 0);
    chk("sw_wstrb", {28'h0, c_wstrb}, 32'hF);
    chk("sw_wdata", c_wdata, 32'hDEADBEEF);
    chk("sw_addr", c_addr, 32'h304);
    chk("sw_we_done", {31'h0, bus_we}, 32'h0);
    tick();

    // Fetch wins over a simultaneous load; the load is dropped
    txn(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 32'h11111111, 0);
    chk("pri_we", {31'h0, c_we}, 32'h0);
    chk("pri_instr", instr, 32'h11111111);
    chk("pri_rd_kept", read_data, 32'h8765ABCD);
    tick();
    chk("pri_no_second_req", {31'h0, bus_req}, 32'h0);
    chk("pri_no_second_busy", {31'h0, busy}, 32'h0);

    // Stray ack in IDLE is ignored
    bus_rdata = 32'hFFFFFFFF; bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    tick();
    chk("stray_instr", instr, 32'h11111111);
    chk("stray_rd", read_data, 32'h8765ABCD);

    // Request held through DONE is accepted in the following IDLE cycle
    txn(1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 32'h210, 32'h0, 32'h0BADCAFE, 0);
    load_req = 1'b1; result = 32'h214; funct3 = 3'b010; bus_rdata = 32'h55AA55AA;
    #1 chk("b2b_done_busy", {31'h0, busy}, 32'h0);
    tick();
    chk("b2b_idle_busy", {31'h0, busy}, 32'h1);
    tick();
    load_req = 1'b0;
    chk("b2b_req", {31'h0, bus_req}, 32'h1);
    chk("b2b_addr", bus_addr, 32'h214);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("b2b_data", read_data, 32'h55AA55AA);
    tick();

    // Fetch timeout after four WAIT cycles
    pc = 32'h180; ir_write = 1'b1;
    tick();
    ir_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tmo_req_w%0d", i), {31'h0, bus_req}, 32'h1);
      tick();
    end
    chk("tmo_req_done", {31'h0, bus_req}, 32'h0);
    chk("tmo_busy", {31'h0, busy}, 32'h0);
    chk("tmo_err", {31'h0, bus_err}, 32'h1);
    chk("tmo_instr", instr, 32'h00000013);
    tick();
    tick();
    chk("tmo_err_sticky", {31'h0, bus_err}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Unified instruction/data memory port controller sitting directly downstream of the multicycle control FSM. Converts per-cycle FSM memory commands (fetch, load, store) into single-outstanding bus transactions with byte-lane steering, sign/zero extension and a wait-state handshake. Returns a busy stall to the FSM, which holds its state while busy is high. Owns the instruction register and old-PC register.

Parameters:
TIMEOUT_CYCLES, 255, max cycles WAIT holds bus_req without bus_ack before abort; must be ≥1
NOP_INSTR, 32'h00000013, value loaded into instr on an aborted fetch

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
pc  in  32  current PC, fetch address
result  in  32  ALU/result bus, data address
adr_src  in  1  0: address = pc, 1: address = result
ir_write  in  1  fetch request
mem_write  in  1  store request
load_req  in  1  load request
funct3  in  3  access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
write_data  in  32  store data, low-aligned
busy  out  1  stall to FSM
instr  out  32  instruction register
old_pc  out  32  PC of the instruction held in instr
read_data  out  32  extended load data
bus_err  out  1  sticky timeout flag
bus_req  out  1  bus request
bus_we  out  1  bus write enable
bus_addr  out  32  word-aligned address, bits [1:0] = 0
bus_wdata  out  32  lane-steered store data
bus_wstrb  out  4  byte-lane write strobes
bus_rdata  in  32  bus read data
bus_ack  in  1  bus completion, one cycle

Behaviour:
- FSM states: IDLE, WAIT, DONE. Reset value: IDLE. Reset value of every registered output is 0, including instr, old_pc, read_data, bus_err, bus_req and bus_we.
- IDLE: accept any request. Priority is ir_write > mem_write > load_req; lower-priority requests in the same cycle are dropped. On accept, latch:
  - kind
  - address (mux by adr_src)
  - byte offset = addr[1:0]
  - funct3
  - pc
  - steered wdata/wstrb
  Then go to WAIT.
- busy = (IDLE and any request) or WAIT. It is 0 in DONE.
- WAIT: bus_req = 1; bus_we = 1 only for store. bus_addr, bus_wdata and bus_wstrb hold stable until ack.
  - For loads and fetches, bus_wstrb = 0.
  - On bus_ack: fetch loads instr <= bus_rdata and old_pc <= latched pc; load updates read_data; store changes no register. Then go to DONE.
  - bus_req deasserts in the cycle after ack.
- Store steering:
  - sb: wdata byte replicated to all lanes, wstrb = 1 << offset.
  - sh: halfword replicated, wstrb = 0011 for offset 0 or 1, 1100 for offset 2 or 3.
  - sw: wstrb = 1111.
- Load extraction: select byte or halfword by offset (halfword uses offset[1]). lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.
- Undefined funct3 on a load or store is treated as word.
- Timeout: a counter clears on entry to WAIT. If it reaches TIMEOUT_CYCLES with no ack:
  - bus_err is set (sticky until reset);
  - a fetch loads instr = NOP_INSTR;
  - a load sets read_data = 0;
  - go to DONE.
- DONE: lasts one cycle, then IDLE. Requests present in DONE are ignored, because the FSM advances on this edge.
- Back-to-back: a request present in the cycle after DONE is accepted. Minimum throughput is 1 transaction per 3 cycles with zero-wait ack.
- bus_ack received outside WAIT is ignored.
- Reset mid-transaction: state, bus_req and bus_we clear immediately (asynchronously); no register update occurs.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - A halfword access at odd offset, or a word access at offset ≠ 0, is not issued to the bus.
  - The block goes IDLE→DONE directly; busy is high for the accept cycle only.
  - Output misalign (1 bit) pulses for one cycle in DONE.
  - read_data is set to 0.
  - A misaligned fetch (pc[1:0] ≠ 0) behaves the same and leaves instr unchanged.
- Undefined: the misalign port is absent. Misaligned accesses proceed using offset steering as above; sw and lw ignore the offset.

Test Plan:
- Fetch, pc=0x100, adr_src=0, bus_rdata=0x00A00093, ack after 2 wait cycles → bus_addr=0x100, busy high 4 cycles, instr=0x00A00093, old_pc=0x100.
- Load lb, result=0x203, bus_rdata=0x80FF_0000 → read_data=0xFFFFFF80; lbu at the same address → 0x00000080; lh at 0x202 → 0xFFFF80FF.
- Store sb, result=0x301, write_data=0x000000AB → bus_we=1, wstrb=0010, wdata=0xABABABAB, addr=0x300; sh at 0x302 → wstrb=1100.
- ir_write and load_req both high → only a fetch is issued, one bus transaction.
- No ack with TIMEOUT_CYCLES=4 on a fetch → bus_req low after 4 WAIT cycles, bus_err=1, instr=0x00000013, busy drops.
- Reset asserted during WAIT → bus_req=0 in the same cycle, instr unchanged; after release a new fetch proceeds normally.
